sub_shift_serial: RTL and testbench
===================================

Name: sub_shift_serial

Overview:
- Byte-serial AES round front end: accepts a 128-bit state and substitutes its 16 bytes through a single S-box lookup instance, one byte per cycle.
- Applies the ShiftRows permutation on write-back and presents the result downstream.
- Sits between the AddRoundKey stage (upstream) and MixColumns (downstream).
- Trades area (one S-box instead of 16) for latency.

Parameters:
- SHIFT_EN, 1, 1 = apply ShiftRows on write-back; 0 = SubBytes only (result byte i = S(input byte i)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a state word
- in_ready  output  1  block can accept a state word
- state_in  input  128  input state; byte i = state_in[127-8i -: 8], column-major (row r = i mod 4, col c = i div 4)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- state_out  output  128  result state, same byte ordering
- abort  input  1  synchronous discard of any in-flight or held state
- busy  output  1  high in SUB or DONE

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, cnt=0, in_ready=1, out_valid=0, busy=0, state_out=0, internal source register=0.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid&in_ready: latch state_in into source register, cnt<=0, go to SUB.
- SUB:
  - in_ready=0.
  - Each cycle, byte cnt of the source register drives the S-box; its output is written into the result register at position dst(cnt), then cnt<=cnt+1.
  - Byte at (r,c) moves to (r,(c-r) mod 4); i.e. out(r,c)=S(in(r,(c+r) mod 4)).
  - dst(i) = r + 4*((c - r) mod 4) with r = i mod 4, c = i div 4 when SHIFT_EN=1; dst(i) = i otherwise.
  - On the edge where cnt==15 is processed: cnt<=0, go to DONE.
- DONE:
  - out_valid=1; state_out holds the result register, stable until accepted.
  - On edge with out_ready=1: go to IDLE, out_valid<=0.
  - state_out keeps its last value after acceptance; it does not clear.
- Latency:
  - Acceptance edge E0; bytes processed on edges E1..E16.
  - out_valid high in the cycle after E16, i.e. 16 cycles after acceptance.
  - If out_ready is already high, handback occurs at E17.
  - Minimum initiation interval 18 cycles (IDLE cycle needed to re-accept).
- No overlap: in_ready is low in SUB and DONE even if out_ready is high. A new word is never accepted in the same cycle a result is handed off.
- Backpressure: out_ready low holds DONE indefinitely; state_out and out_valid are stable.
- in_valid while not ready: ignored; state_in is not sampled.
- abort (synchronous, highest priority over all transitions):
  - From any state, next edge: FSM=IDLE, cnt=0, out_valid=0; result register is left unchanged.
  - abort together with in_valid in IDLE: abort wins, nothing is accepted.
- Async reset mid-SUB or mid-DONE: immediate return to reset values; partial results are discarded.
- cnt is 4 bits; it wraps only via the explicit cnt==15 transition.
- The S-box path is purely combinational in one cycle: source mux → lookup → result write.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, state_out=0, busy=0.
- FIPS-197 vector, SHIFT_EN=1:
  - state_in=193de3bea0f4e22b9ac68d2ae9f84808 → after 16 cycles out_valid=1.
  - state_out=d4bf5d30e0b452aeb84111f11e2798e5.
- Same input, SHIFT_EN=0: state_out=d42711aee0bf98f1b8b45de51e415230.
- All-zero input: state_out=63636363636363636363636363636363 for either SHIFT_EN setting.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - state_out stays stable; in_ready stays 0.
  - Second in_valid is not accepted until one cycle after the out_ready handshake.
- Mid-operation disruption:
  - abort asserted at cnt=7 → IDLE next edge, no out_valid.
  - rst_n pulsed low at cnt=9 → immediate reset values; a subsequent zero vector yields 63…63.

Source files
------------

// File: rtl/sub_shift_serial_if.sv
// Handshake and data bundle between AddRoundKey (master side) and the
// byte-serial SubBytes/ShiftRows front end (slave side).
interface sub_shift_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         abort;
    logic         busy;

    modport master (
        output in_valid, state_in, out_ready, abort,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready, abort,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/sub_shift_serial.sv
// Byte-serial AES SubBytes + ShiftRows front end.
// One S-box instance substitutes one byte per cycle; the ShiftRows
// permutation is folded into the write-back address of the result register.
module sub_shift_serial #(
    parameter bit SHIFT_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    sub_shift_serial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;

    logic [7:0]   sboxIn;
    logic [7:0]   sboxOut;
    logic [1:0]   dstCol;
    logic [3:0]   dstIdx;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add with xtime).
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    // AES S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sboxLookup(input logic [7:0] a);
        logic [7:0] b;
        b = gfInv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Select source byte cnt_q (byte 0 is the most significant byte).
    always_comb begin
        sboxIn = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (cnt_q == i[3:0]) sboxIn = src_q[127 - 8*i -: 8];
        end
    end

    assign sboxOut = sboxLookup(sboxIn);

    // Row r = cnt[1:0], column c = cnt[3:2]; ShiftRows moves (r,c) to (r,c-r).
    assign dstCol = cnt_q[3:2] - cnt_q[1:0];
    assign dstIdx = SHIFT_EN ? {dstCol, cnt_q[1:0]} : cnt_q;

    // State, counter and data registers; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic; abort overrides every transition but keeps the result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_d   = bus.state_in;
                        cnt_d   = 4'd0;
                        state_d = SUB;
                    end
                end
                SUB: begin
                    for (int i = 0; i < 16; i++) begin
                        if (dstIdx == i[3:0]) res_d[127 - 8*i -: 8] = sboxOut;
                    end
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == SUB) || (state_q == DONE);
    assign bus.state_out = res_q;

endmodule

// File: tb/tb_sub_shift_serial.sv
// Bench for sub_shift_serial: two instances (ShiftRows on and off) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_sub_shift_serial;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         inValid = 1'b0;
    logic [127:0] stateIn = '0;
    logic         outReady = 1'b0;
    logic         abortIn = 1'b0;

    int total = 0;
    int bad = 0;
    int handoffs = 0;

    sub_shift_serial_if ifA();
    sub_shift_serial_if ifB();

    assign ifA.in_valid  = inValid;
    assign ifA.state_in  = stateIn;
    assign ifA.out_ready = outReady;
    assign ifA.abort     = abortIn;
    assign ifB.in_valid  = inValid;
    assign ifB.state_in  = stateIn;
    assign ifB.out_ready = outReady;
    assign ifB.abort     = abortIn;

    sub_shift_serial #(.SHIFT_EN(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    sub_shift_serial #(.SHIFT_EN(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    always #5 clk = ~clk;

    // Reference S-box table, built by brute-force inverse search
    logic [7:0] sbox [256];

    // Polynomial multiply then reduce modulo 0x11b
    function automatic logic [7:0] polyMulMod(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        inv = 8'h00;
        cst = 8'h63;
        for (int y = 1; y < 256; y++) if (polyMulMod(a, 8'(y)) == 8'h01) inv = 8'(y);
        for (int k = 0; k < 8; k++)
            s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ cst[k];
        return s;
    endfunction

    // Whole-state result: out(r,c) = S(in(r,(c+r) mod 4)) or S(in(r,c))
    function automatic logic [127:0] refRound(input logic [127:0] w, input int shiftEn);
        logic [127:0] res;
        int srcCol;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                srcCol = (shiftEn != 0) ? (c + r) % 4 : c;
                res[127 - 8*(r + 4*c) -: 8] = sbox[w[127 - 8*(r + 4*srcCol) -: 8]];
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: bytes still to substitute, and whether a result is held
    int           mLeft = 0;
    bit           mHeld = 1'b0;
    logic [127:0] mSrc = '0;
    logic [127:0] mRes [2];

    task automatic modelStep();
        int k;
        int r;
        int c;
        int dc;
        if (!rst_n) begin
            mLeft = 0;
            mHeld = 1'b0;
            mSrc = '0;
            mRes[0] = '0;
            mRes[1] = '0;
        end else if (abortIn) begin
            mLeft = 0;
            mHeld = 1'b0;
        end else if (mHeld) begin
            if (outReady) begin
                mHeld = 1'b0;
                handoffs++;
            end
        end else if (mLeft > 0) begin
            k = 16 - mLeft;
            r = k % 4;
            c = k / 4;
            dc = (c - r + 4) % 4;
            mRes[1][127 - 8*(r + 4*dc) -: 8] = sbox[mSrc[127 - 8*k -: 8]];
            mRes[0][127 - 8*k -: 8] = sbox[mSrc[127 - 8*k -: 8]];
            mLeft--;
            if (mLeft == 0) mHeld = 1'b1;
        end else if (inValid) begin
            mSrc = stateIn;
            mLeft = 16;
        end
    endtask

    task automatic compareOne(input string tag, input int v, input logic ir, input logic ov,
                              input logic bz, input logic [127:0] so);
        bit idle;
        idle = !mHeld && (mLeft == 0);
        checkOutput({tag, "_in_ready"}, 128'(ir), 128'(idle));
        checkOutput({tag, "_out_valid"}, 128'(ov), 128'(mHeld));
        checkOutput({tag, "_busy"}, 128'(bz), 128'(!idle));
        checkOutput({tag, "_state_out"}, so, mRes[v]);
        if (mHeld) checkOutput({tag, "_final"}, so, refRound(mSrc, v));
    endtask

    // Advance the model on each edge and compare both instances just after it
    always @(posedge clk) begin
        modelStep();
        #1;
        compareOne("A", 1, ifA.in_ready, ifA.out_valid, ifA.busy, ifA.state_out);
        compareOne("B", 0, ifB.in_ready, ifB.out_valid, ifB.busy, ifB.state_out);
    end

    // Present one word from idle and wait (bounded) for out_valid
    task automatic applyStimulus(input logic [127:0] w, output int lat);
        @(negedge clk);
        inValid = 1'b1;
        stateIn = w;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!ifA.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_63   = {16{8'h63}};

    initial begin
        int lat;
        int waited;
        logic [127:0] vecX;
        logic [127:0] vecY;

        for (int a = 0; a < 256; a++) sbox[a] = refSbox(8'(a));
        mRes[0] = '0;
        mRes[1] = '0;

        // Pin the model with known S-box entries and the FIPS-197 round values
        checkOutput("model_sbox_00", 128'(sbox[8'h00]), 128'h63);
        checkOutput("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
        checkOutput("model_sbox_01", 128'(sbox[8'h01]), 128'h7c);
        checkOutput("model_fips_sr", refRound(FIPS_IN, 1), FIPS_SR);
        checkOutput("model_fips_sb", refRound(FIPS_IN, 0), FIPS_SB);

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_in_ready", 128'(ifA.in_ready), 128'd1);
        checkOutput("reset_out_valid", 128'(ifA.out_valid), 128'd0);
        checkOutput("reset_state_out", ifA.state_out, 128'd0);
        checkOutput("reset_busy", 128'(ifB.busy), 128'd0);

        // FIPS vector, latency and both permutation settings
        applyStimulus(FIPS_IN, lat);
        checkOutput("fips_latency", 128'(lat), 128'd17);
        checkOutput("fips_shift_on", ifA.state_out, FIPS_SR);
        checkOutput("fips_shift_off", ifB.state_out, FIPS_SB);
        releaseResult();

        // All-zero input
        applyStimulus('0, lat);
        checkOutput("zero_latency", 128'(lat), 128'd17);
        checkOutput("zero_shift_on", ifA.state_out, ALL_63);
        checkOutput("zero_shift_off", ifB.state_out, ALL_63);
        releaseResult();

        // Backpressure: result stable for 10 cycles, next word waits for the handshake
        vecX = {$urandom, $urandom, $urandom, $urandom};
        vecY = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(vecX, lat);
        checkOutput("bp_latency", 128'(lat), 128'd17);
        inValid = 1'b1;
        stateIn = vecY;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 128'(ifA.in_ready), 128'd0);
            checkOutput("bp_out_valid", 128'(ifA.out_valid), 128'd1);
            checkOutput("bp_stable", ifA.state_out, refRound(vecX, 1));
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("bp_no_same_cycle_accept", 128'(ifA.busy), 128'd0);
        checkOutput("bp_idle_in_ready", 128'(ifA.in_ready), 128'd1);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("bp_second_accepted", 128'(ifA.busy), 128'd1);
        waited = 0;
        while (!ifA.out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_second_wait", 128'(waited), 128'd16);
        checkOutput("bp_second_on", ifA.state_out, refRound(vecY, 1));
        checkOutput("bp_second_off", ifB.state_out, refRound(vecY, 0));
        releaseResult();

        // Abort at cnt=7, then abort racing in_valid in idle
        @(negedge clk);
        inValid = 1'b1;
        stateIn = FIPS_IN;
        @(negedge clk);
        inValid = 1'b0;
        repeat (7) @(negedge clk);
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        checkOutput("abort_busy", 128'(ifA.busy), 128'd0);
        checkOutput("abort_in_ready", 128'(ifA.in_ready), 128'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("abort_no_out_valid", 128'(ifA.out_valid), 128'd0);
        end
        inValid = 1'b1;
        abortIn = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        abortIn = 1'b0;
        checkOutput("abort_beats_accept", 128'(ifB.busy), 128'd0);

        // Async reset at cnt=9, then a zero vector
        @(negedge clk);
        inValid = 1'b1;
        stateIn = FIPS_IN;
        @(negedge clk);
        inValid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_in_ready", 128'(ifA.in_ready), 128'd1);
        checkOutput("mid_reset_busy", 128'(ifA.busy), 128'd0);
        checkOutput("mid_reset_state_out", ifA.state_out, 128'd0);
        checkOutput("mid_reset_state_out_b", ifB.state_out, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('0, lat);
        checkOutput("post_reset_latency", 128'(lat), 128'd17);
        checkOutput("post_reset_on", ifA.state_out, ALL_63);
        checkOutput("post_reset_off", ifB.state_out, ALL_63);
        releaseResult();

        // Randomised traffic with random backpressure and rare aborts
        handoffs = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            inValid  = ($urandom_range(0, 2) != 0);
            stateIn  = {$urandom, $urandom, $urandom, $urandom};
            outReady = ($urandom_range(0, 3) == 0);
            abortIn  = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        inValid = 1'b0;
        outReady = 1'b0;
        abortIn = 1'b0;
        @(negedge clk);
        checkOutput("random_handoffs_seen", 128'(handoffs > 5), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
